// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg
//   Shared constants for the decode stage: MIPS-style opcode and funct
//   encodings, the R/I/J instruction-type encodings, the canonical
//   illegal opcode and the width of a decoded bundle.
//   No ports; imported by decode_queue and bundle_fifo.
package decode_queue_pkg;

    // Instruction type encodings driven on out_inst_type
    localparam logic [1:0] TYPE_R = 2'd0;
    localparam logic [1:0] TYPE_I = 2'd1;
    localparam logic [1:0] TYPE_J = 2'd2;

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;   // BGEZ / BLTZ, selected by rt
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // Unassigned opcode, the canonical illegal instruction
    localparam logic [5:0] OP_ERR    = 6'h3F;

    // R-type shift functs (the only R-type forms that carry an immediate)
    localparam logic [5:0] FN_SLL    = 6'h00;
    localparam logic [5:0] FN_SRL    = 6'h02;
    localparam logic [5:0] FN_SRA    = 6'h03;

    // Bundle layout, MSB first:
    //   pc | inst_type | op_code | funct | rs | rt | rd | shamt | imm | is_load | illegal
    function automatic int unsigned bundle_w(input int unsigned w, input int unsigned ra_w);
        return 2 * w + 2 + 6 + 6 + 3 * ra_w + 5 + 1 + 1;
    endfunction

endpackage

// File: rtl/decode_queue_bundle_fifo.sv
// bundle_fifo
//   Small FIFO holding decoded bundles. The head entry is kept in its own
//   register so the consumer-facing data is register-driven and holds its
//   last value while the FIFO is empty.
//   Ports:
//     clk, rst      clock, synchronous active-low reset
//     push_i        write wdata_i at the tail (ignored when full or flushing)
//     pop_i         drop the head entry (ignored when empty or flushing)
//     flush_i       empty the FIFO; same-cycle push and pop are void
//     wdata_i       bundle to enqueue
//     full_o        DEPTH entries held
//     empty_o       no entries held
//     head_o        registered head bundle
//   DEPTH must be a power of two (2..8) so the pointers wrap naturally.
module bundle_fifo
    import decode_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [PTR_W-1:0]  rd_next;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = head_q;

    assign do_push = push_i && !full_o  && !flush_i;
    assign do_pop  = pop_i  && !empty_o && !flush_i;
    assign rd_next = rd_ptr_q + PTR_W'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_next;
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);

            // Next head: the following stored entry if there is one, else the
            // entry being written this cycle, else keep the old value.
            if (do_pop) begin
                if (cnt_q > CNT_W'(1)) begin
                    head_d = mem_q[rd_next];
                end else if (do_push) begin
                    head_d = wdata_i;
                end
            end else if (empty_o && do_push) begin
                head_d = wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    // Storage needs no reset; an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue
//   Registered instruction-decode stage between fetch and issue. Each
//   accepted instruction is cracked into fields plus an extended immediate
//   (or absolute jump target) and buffered in bundle_fifo. A one-bubble
//   load-use interlock and a synchronous flush are enforced here.
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     flush                    discard buffered and incoming instructions
//     in_valid/in_ready        fetch handshake; in_inst, in_pc payload
//     out_valid/out_ready      issue handshake on the head bundle
//     out_pc .. out_illegal    registered fields of the head bundle
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int W          = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_inst,
    input  logic [W-1:0]          in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_pc,
    output logic [1:0]            out_inst_type,
    output logic [5:0]            out_op_code,
    output logic [5:0]            out_funct,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [4:0]            out_shamt,
    output logic [W-1:0]          out_imm,
    output logic                  out_is_load,
    output logic                  out_illegal
);

    localparam int BUNDLE_W = int'(bundle_w(W, REG_ADDR_W));

    logic [5:0]            op, funct;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [4:0]            shamt;
    logic [1:0]            inst_type;
    logic [W-1:0]          imm;
    logic                  is_load, illegal, reads_rt;
    logic [3:0]            pc4_hi;

    logic [REG_ADDR_W-1:0] last_load_rt_q, last_load_rt_d;
    logic                  interlock, push, pop;
    logic                  fifo_full, fifo_empty;
    logic [BUNDLE_W-1:0]   bundle_in, bundle_head;

    // Top nibble of pc+4: adding 4 only carries into it when pc[W-5:2] is all ones.
    assign pc4_hi = in_pc[W-1:W-4] + {3'b000, &in_pc[W-5:2]};

    always_comb begin
        op        = in_inst[31:26];
        funct     = in_inst[5:0];
        rs        = REG_ADDR_W'(in_inst[25:21]);
        rt        = REG_ADDR_W'(in_inst[20:16]);
        rd        = REG_ADDR_W'(in_inst[15:11]);
        shamt     = in_inst[10:6];
        inst_type = TYPE_I;
        imm       = '0;
        is_load   = 1'b0;
        illegal   = 1'b0;
        reads_rt  = 1'b0;
        case (op)
            OP_RTYPE: begin
                inst_type = TYPE_R;
                reads_rt  = 1'b1;
                if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) begin
                    imm = W'(shamt);
                end
            end
            OP_REGIMM, OP_BLEZ, OP_BGTZ: begin
                imm = W'($signed({in_inst[15:0], 2'b00}));
            end
            OP_BEQ, OP_BNE: begin
                imm      = W'($signed({in_inst[15:0], 2'b00}));
                reads_rt = 1'b1;
            end
            OP_J, OP_JAL: begin
                inst_type = TYPE_J;
                imm       = W'({pc4_hi, in_inst[25:0], 2'b00});
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                imm = W'($signed(in_inst[15:0]));
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                imm = W'(in_inst[15:0]);
            end
            OP_LUI: begin
                imm = W'({in_inst[15:0], 16'h0000});
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                imm     = W'($signed(in_inst[15:0]));
                is_load = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                imm      = W'($signed(in_inst[15:0]));
                reads_rt = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign interlock = in_valid && (last_load_rt_q != '0) &&
                       ((rs == last_load_rt_q) || (reads_rt && (rt == last_load_rt_q)));

    // No path from out_ready: a full FIFO refuses input even while draining.
    assign in_ready = rst && !fifo_full && !interlock;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready;

    // Clearing on interlock is what limits the stall to a single bubble.
    always_comb begin
        last_load_rt_d = last_load_rt_q;
        if (flush) begin
            last_load_rt_d = '0;
        end else if (push) begin
            last_load_rt_d = is_load ? rt : '0;
        end else if (interlock) begin
            last_load_rt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_load_rt_q <= '0;
        end else begin
            last_load_rt_q <= last_load_rt_d;
        end
    end

    assign bundle_in = {in_pc, inst_type, op, funct, rs, rt, rd, shamt, imm, is_load, illegal};

    bundle_fifo #(
        .DATA_W (BUNDLE_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (bundle_in),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (bundle_head)
    );

    assign out_valid = !fifo_empty;
    assign {out_pc, out_inst_type, out_op_code, out_funct, out_rs, out_rt, out_rd,
            out_shamt, out_imm, out_is_load, out_illegal} = bundle_head;

endmodule
